spi_bitrev_slave: RTL and testbench

Parametrised SPI slave for the perip test peripherals, the successor of the fixed 8-bit bit-reversal slave. It receives a DATA_W-bit frame on MOSI, then returns either its bit-reversed value or an unmodified echo on MISO in the next DATA_W-bit frame, within a single SS assertion. All logic runs on the system clock, and sck/ss/mosi are oversampled through synchronisers. It supports all four CPOL/CPHA modes and exposes status to the SoC side.

---
 rtl/spi_bitrev_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_bitrev_slave.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bitrev_slave.sv
// SPI slave that captures one DATA_W-bit frame on MOSI and returns it bit-reversed
// (or echoed) on MISO in the next frame, fully oversampled on the system clock.
module spi_bitrev_slave #(
   parameter int DATA_W  = 8,
   parameter int CPOL    = 0,
   parameter int CPHA    = 0,
   parameter int REVERSE = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sck,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              abort,
   output logic [15:0]       frame_cnt
);

   localparam int   CNT_W  = $clog2(DATA_W) + 1;
   localparam logic CPOL_L = (CPOL != 0);

   typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

   state_t              state_q, state_d;
   logic                sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_s3_q, sck_s3_d;
   logic                ss_s1_q, ss_s1_d, ss_s2_q, ss_s2_d, ss_s3_q, ss_s3_d;
   logic                mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                abort_q, abort_d;
   logic                miso_q, miso_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic                sck_edge, lead_edge, trail_edge, sample;
   logic                last_bit;
   logic [DATA_W-1:0]   rx_next;

   function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = v[DATA_W-1-i];
      end
      return r;
   endfunction

   always_comb begin
      sck_s1_d  = sck;
      sck_s2_d  = sck_s1_q;
      sck_s3_d  = sck_s2_q;
      ss_s1_d   = ss;
      ss_s2_d   = ss_s1_q;
      ss_s3_d   = ss_s2_q;
      mosi_s1_d = mosi;
      mosi_s2_d = mosi_s1_q;
   end

   // Edges are only meaningful while the synced select is active.
   assign sck_edge   = (sck_s2_q != sck_s3_q) && !ss_s2_q;
   assign lead_edge  = sck_edge && (sck_s2_q != CPOL_L);
   assign trail_edge = sck_edge && (sck_s2_q == CPOL_L);
   assign sample     = (CPHA != 0) ? trail_edge : lead_edge;
   assign last_bit   = (bit_cnt_q == CNT_W'(DATA_W - 1));
   assign rx_next    = {rx_sr_q[DATA_W-2:0], mosi_s2_q};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      abort_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;

      // A select deassert wins over any sample edge seen in the same cycle.
      if (ss_s2_q && (state_q != IDLE)) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         rx_sr_d   = '0;
         tx_sr_d   = '0;
         abort_d   = (state_q == TX) || ((state_q == RX) && (bit_cnt_q != '0));
      end else begin
         case (state_q)
            IDLE: begin
               if (!ss_s2_q && ss_s3_q) begin
                  state_d   = RX;
                  bit_cnt_d = '0;
                  rx_sr_d   = '0;
               end
            end
            RX: begin
               if (sample) begin
                  rx_sr_d = rx_next;
                  if (last_bit) begin
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                     tx_sr_d    = (REVERSE != 0) ? bitrev(rx_next) : rx_next;
                     bit_cnt_d  = '0;
                     state_d    = TX;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            TX: begin
               if (sample) begin
                  tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                  if (last_bit) begin
                     bit_cnt_d   = '0;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     state_d     = DONE;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end

      miso_d = (state_d == TX) ? tx_sr_d[DATA_W-1] : 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_s1_q    <= CPOL_L;
         sck_s2_q    <= CPOL_L;
         sck_s3_q    <= CPOL_L;
         ss_s1_q     <= 1'b1;
         ss_s2_q     <= 1'b1;
         ss_s3_q     <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         abort_q     <= 1'b0;
         miso_q      <= 1'b1;
         frame_cnt_q <= '0;
      end else begin
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_s3_q    <= sck_s3_d;
         ss_s1_q     <= ss_s1_d;
         ss_s2_q     <= ss_s2_d;
         ss_s3_q     <= ss_s3_d;
         mosi_s1_q   <= mosi_s1_d;
         mosi_s2_q   <= mosi_s2_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         abort_q     <= abort_d;
         miso_q      <= miso_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign miso      = miso_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign busy      = (state_q == RX) || (state_q == TX);
   assign abort     = abort_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Directed bench: mode 0 / 8-bit reversing slave plus two mode 3 / 16-bit slaves
// (reversing and echo) sharing one SPI bus.
module tb_spi_bitrev_slave;

   localparam int HALF = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        sck_a = 1'b0, ss_a = 1'b1, mosi_a = 1'b0;
   logic        miso_a, rxv_a, busy_a, abort_a;
   logic [7:0]  rx_data_a;
   logic [15:0] frame_cnt_a;

   logic        sck_b = 1'b1, ss_b = 1'b1, mosi_b = 1'b0;
   logic        miso_r, rxv_r, busy_r, abort_r;
   logic [15:0] rx_data_r, frame_cnt_r;
   logic        miso_e, rxv_e, busy_e, abort_e;
   logic [15:0] rx_data_e, frame_cnt_e;

   int checks = 0;
   int errors = 0;
   int rxv_cnt_a = 0, abort_cnt_a = 0;
   int rxv_cnt_r = 0, abort_cnt_r = 0;
   int rxv_cnt_e = 0, abort_cnt_e = 0;

   spi_bitrev_slave #(.DATA_W(8), .CPOL(0), .CPHA(0), .REVERSE(1)) u_m0 (
      .clock(clock), .reset(reset), .sck(sck_a), .ss(ss_a), .mosi(mosi_a),
      .miso(miso_a), .rx_valid(rxv_a), .rx_data(rx_data_a), .busy(busy_a),
      .abort(abort_a), .frame_cnt(frame_cnt_a)
   );

   spi_bitrev_slave #(.DATA_W(16), .CPOL(1), .CPHA(1), .REVERSE(1)) u_m3r (
      .clock(clock), .reset(reset), .sck(sck_b), .ss(ss_b), .mosi(mosi_b),
      .miso(miso_r), .rx_valid(rxv_r), .rx_data(rx_data_r), .busy(busy_r),
      .abort(abort_r), .frame_cnt(frame_cnt_r)
   );

   spi_bitrev_slave #(.DATA_W(16), .CPOL(1), .CPHA(1), .REVERSE(0)) u_m3e (
      .clock(clock), .reset(reset), .sck(sck_b), .ss(ss_b), .mosi(mosi_b),
      .miso(miso_e), .rx_valid(rxv_e), .rx_data(rx_data_e), .busy(busy_e),
      .abort(abort_e), .frame_cnt(frame_cnt_e)
   );

   always #5 clock = ~clock;

   // Pulse counters: each counts clock cycles the pulse output was high.
   always @(negedge clock) begin
      if (rxv_a)   rxv_cnt_a++;
      if (abort_a) abort_cnt_a++;
      if (rxv_r)   rxv_cnt_r++;
      if (abort_r) abort_cnt_r++;
      if (rxv_e)   rxv_cnt_e++;
      if (abort_e) abort_cnt_e++;
   end

   // Mode 0 master: drive MOSI while SCK low, sample MISO on the rising edge.
   task automatic xfer_a(input logic [31:0] data, input int nbits, input int npulses,
                         output logic [63:0] got);
      got  = '0;
      ss_a = 1'b0;
      repeat (8) @(negedge clock);
      for (int i = 0; i < npulses; i++) begin
         mosi_a = (i < nbits) ? data[nbits-1-i] : 1'b0;
         repeat (HALF) @(negedge clock);
         sck_a = 1'b1;
         got   = {got[62:0], miso_a};
         repeat (HALF) @(negedge clock);
         sck_a = 1'b0;
      end
      repeat (HALF) @(negedge clock);
   endtask

   task automatic end_a();
      ss_a = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   // Mode 3 master: drive on the falling (leading) edge, sample on the rising edge.
   task automatic xfer_b(input logic [31:0] data, input int nbits, input int npulses,
                         output logic [63:0] got_r, output logic [63:0] got_e);
      got_r = '0;
      got_e = '0;
      ss_b  = 1'b0;
      repeat (8) @(negedge clock);
      for (int i = 0; i < npulses; i++) begin
         sck_b  = 1'b0;
         mosi_b = (i < nbits) ? data[nbits-1-i] : 1'b0;
         repeat (HALF) @(negedge clock);
         sck_b = 1'b1;
         got_r = {got_r[62:0], miso_r};
         got_e = {got_e[62:0], miso_e};
         repeat (HALF) @(negedge clock);
      end
      repeat (HALF) @(negedge clock);
      ss_b = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ss_a  = 1'b0;
      ss_b  = 1'b0;
      @(negedge clock);
      for (int c = 0; c < 3; c++) begin
         sck_a = ~sck_a;
         sck_b = ~sck_b;
         @(negedge clock);
         checks++;
         if (miso_a !== 1'b1 || miso_r !== 1'b1 || miso_e !== 1'b1) begin
            errors++;
            $display("FAIL reset_miso: got %b%b%b expected 111", miso_a, miso_r, miso_e);
         end
         checks++;
         if (busy_a !== 1'b0 || busy_r !== 1'b0 || busy_e !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b%b%b expected 000", busy_a, busy_r, busy_e);
         end
         checks++;
         if (rx_data_a !== 8'h00 || rx_data_r !== 16'h0000 || frame_cnt_a !== 16'h0000
             || frame_cnt_r !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: rx_data %h/%h frame_cnt %h/%h expected zeros",
                     rx_data_a, rx_data_r, frame_cnt_a, frame_cnt_r);
         end
      end
      ss_a  = 1'b1;
      ss_b  = 1'b1;
      sck_a = 1'b0;
      sck_b = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      checks++;
      if (rxv_cnt_a + rxv_cnt_r + rxv_cnt_e + abort_cnt_a + abort_cnt_r + abort_cnt_e != 0) begin
         errors++;
         $display("FAIL reset_pulses: got %0d rx_valid/abort cycles expected 0",
                  rxv_cnt_a + rxv_cnt_r + rxv_cnt_e + abort_cnt_a + abort_cnt_r + abort_cnt_e);
      end
   endtask

   task automatic test_mode0();
      logic [63:0] got;
      int          rxv0, ab0;
      rxv0 = rxv_cnt_a;
      ab0  = abort_cnt_a;
      xfer_a(32'h01, 8, 16, got);
      checks++;
      if (got[15:0] !== 16'hFF80) begin
         errors++;
         $display("FAIL mode0_miso: got %h expected ff80", got[15:0]);
      end
      checks++;
      if (rx_data_a !== 8'h01 || rxv_cnt_a - rxv0 != 1) begin
         errors++;
         $display("FAIL mode0_rx: rx_data %h pulses %0d expected 01 and 1",
                  rx_data_a, rxv_cnt_a - rxv0);
      end
      checks++;
      if (frame_cnt_a !== 16'd1 || miso_a !== 1'b1) begin
         errors++;
         $display("FAIL mode0_done: frame_cnt %0d miso %b expected 1 and 1", frame_cnt_a, miso_a);
      end
      end_a();
      checks++;
      if (abort_cnt_a != ab0 || busy_a !== 1'b0 || miso_a !== 1'b1) begin
         errors++;
         $display("FAIL mode0_end: abort cycles %0d busy %b miso %b expected 0 0 1",
                  abort_cnt_a - ab0, busy_a, miso_a);
      end
   endtask

   task automatic test_mode3();
      logic [63:0] got_r, got_e;
      xfer_b(32'h00F3, 16, 32, got_r, got_e);
      checks++;
      if (got_r[31:0] !== 32'hFFFF_CF00) begin
         errors++;
         $display("FAIL mode3_rev_miso: got %h expected ffffcf00", got_r[31:0]);
      end
      checks++;
      if (got_e[31:0] !== 32'hFFFF_00F3) begin
         errors++;
         $display("FAIL mode3_echo_miso: got %h expected ffff00f3", got_e[31:0]);
      end
      checks++;
      if (rx_data_r !== 16'h00F3 || rx_data_e !== 16'h00F3 || rxv_cnt_r != 1 || rxv_cnt_e != 1) begin
         errors++;
         $display("FAIL mode3_rx: rx_data %h/%h pulses %0d/%0d expected 00f3 and 1",
                  rx_data_r, rx_data_e, rxv_cnt_r, rxv_cnt_e);
      end
      checks++;
      if (frame_cnt_r !== 16'd1 || frame_cnt_e !== 16'd1 || abort_cnt_r + abort_cnt_e != 0) begin
         errors++;
         $display("FAIL mode3_cnt: frame_cnt %0d/%0d aborts %0d expected 1/1 and 0",
                  frame_cnt_r, frame_cnt_e, abort_cnt_r + abort_cnt_e);
      end
   endtask

   task automatic test_abort();
      logic [63:0] got;
      int          rxv0, ab0;
      rxv0 = rxv_cnt_a;
      ab0  = abort_cnt_a;
      xfer_a(32'h1B, 8, 5, got);
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy: got %b expected 1", busy_a);
      end
      end_a();
      checks++;
      if (abort_cnt_a - ab0 != 1 || rxv_cnt_a != rxv0) begin
         errors++;
         $display("FAIL abort_pulse: abort cycles %0d rx_valid cycles %0d expected 1 and 0",
                  abort_cnt_a - ab0, rxv_cnt_a - rxv0);
      end
      checks++;
      if (frame_cnt_a !== 16'd1 || rx_data_a !== 8'h01 || busy_a !== 1'b0 || miso_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_state: frame_cnt %0d rx_data %h busy %b miso %b expected 1 01 0 1",
                  frame_cnt_a, rx_data_a, busy_a, miso_a);
      end
      xfer_a(32'hA5, 8, 16, got);
      end_a();
      checks++;
      if (got[15:0] !== 16'hFFA5 || rx_data_a !== 8'hA5) begin
         errors++;
         $display("FAIL abort_next_a5: miso %h rx_data %h expected ffa5 and a5", got[15:0], rx_data_a);
      end
      xfer_a(32'h0F, 8, 16, got);
      end_a();
      checks++;
      if (got[15:0] !== 16'hFFF0 || frame_cnt_a !== 16'd3) begin
         errors++;
         $display("FAIL abort_next_0f: miso %h frame_cnt %0d expected fff0 and 3", got[15:0], frame_cnt_a);
      end
   endtask

   task automatic test_extra_clocks();
      logic [63:0] got;
      int          ab0;
      ab0 = abort_cnt_a;
      xfer_a(32'h12, 8, 20, got);
      end_a();
      checks++;
      if (got[19:0] !== 20'hFF48F) begin
         errors++;
         $display("FAIL extra_miso: got %h expected ff48f", got[19:0]);
      end
      checks++;
      if (frame_cnt_a !== 16'd4 || abort_cnt_a != ab0) begin
         errors++;
         $display("FAIL extra_cnt: frame_cnt %0d aborts %0d expected 4 and 0",
                  frame_cnt_a, abort_cnt_a - ab0);
      end
   endtask

   task automatic test_wrap();
      logic [63:0] got;
      int          ab0;
      ab0 = abort_cnt_a;
      @(negedge clock);
      force u_m0.frame_cnt_q = 16'hFFFE;
      @(negedge clock);
      release u_m0.frame_cnt_q;
      repeat (2) @(negedge clock);
      checks++;
      if (frame_cnt_a !== 16'hFFFE) begin
         errors++;
         $display("FAIL wrap_preload: got %h expected fffe", frame_cnt_a);
      end
      xfer_a(32'hC4, 8, 16, got);
      end_a();
      checks++;
      if (frame_cnt_a !== 16'hFFFF || got[15:0] !== 16'hFF23) begin
         errors++;
         $display("FAIL wrap_ffff: frame_cnt %h miso %h expected ffff and ff23", frame_cnt_a, got[15:0]);
      end
      xfer_a(32'h01, 8, 16, got);
      end_a();
      checks++;
      if (frame_cnt_a !== 16'h0000 || got[15:0] !== 16'hFF80 || rx_data_a !== 8'h01
          || abort_cnt_a != ab0) begin
         errors++;
         $display("FAIL wrap_zero: frame_cnt %h miso %h rx_data %h aborts %0d expected 0000 ff80 01 0",
                  frame_cnt_a, got[15:0], rx_data_a, abort_cnt_a - ab0);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_abort();
      test_extra_clocks();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
